// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC, the nop encoding and
// the RV32I major opcodes seen by the control decoder.
package fetch_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FAULT = 3'd4
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection for the instruction being retired, plus the
// pc+4 link value and a flag for a word-misaligned target.
module next_pc_logic
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] imm_ext,
   input  logic [31:0] alu_result,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   input  logic        jalr,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   assign pc_plus4 = pc + 32'd4;

   // jalr wins over jump/branch; all sums wrap modulo 2^32.
   always_comb begin
      next_pc = pc_plus4;
      if (jalr) begin
         next_pc = alu_result & 32'hFFFF_FFFE;
      end else if (jump || (branch && zero)) begin
         next_pc = pc + imm_ext;
      end
   end

   assign misaligned = next_pc[1];

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request at pc, wait for the word,
// hold it for execute, then advance pc (or stop on a misaligned target).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   output logic         imem_req_valid,
   input  logic         imem_req_ready,
   output logic [31:0]  imem_addr,
   input  logic         imem_rsp_valid,
   input  logic [31:0]  imem_rsp_data,
   output logic         instr_valid,
   output logic [31:0]  instr,
   output logic [31:0]  pc,
   output logic [31:0]  pc_plus4,
   input  logic         instr_ack,
   input  logic         branch,
   input  logic         zero,
   input  logic         jump,
   input  logic         jalr,
   input  logic [31:0]  imm_ext,
   input  logic [31:0]  alu_result,
   output logic         fault,
   output fetch_state_e state
);

   logic [31:0] next_pc;
   logic        next_misaligned;

   next_pc_logic u_next_pc (
      .pc         (pc),
      .imm_ext    (imm_ext),
      .alu_result (alu_result),
      .branch     (branch),
      .zero       (zero),
      .jump       (jump),
      .jalr       (jalr),
      .pc_plus4   (pc_plus4),
      .next_pc    (next_pc),
      .misaligned (next_misaligned)
   );

   assign imem_addr = pc;

   // Handshakes: a request transfers on a cycle with imem_req_valid && imem_req_ready,
   // and valid/addr stay stable until then; a response is taken only in ST_WAIT;
   // the held instr transfers on instr_valid && instr_ack, stable until then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         pc             <= RESET_PC;
         instr          <= NOP_INSTR;
         instr_valid    <= 1'b0;
         imem_req_valid <= 1'b0;
         fault          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state          <= ST_REQ;
               imem_req_valid <= 1'b1;
            end
            ST_REQ: begin
               if (imem_req_ready) begin
                  state          <= ST_WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  instr       <= imem_rsp_data;
                  instr_valid <= 1'b1;
                  state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (instr_ack) begin
                  instr_valid <= 1'b0;
                  if (next_misaligned) begin
                     fault <= 1'b1;
                     state <= ST_FAULT;
                  end else begin
                     pc             <= next_pc;
                     imem_req_valid <= 1'b1;
                     state          <= ST_REQ;
                  end
               end
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: begin
               state          <= ST_IDLE;
               imem_req_valid <= 1'b0;
               instr_valid    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized fetch/ack traffic against a
// plain-arithmetic PC model, plus the stall, branch, fault, reset and wrap cases.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TB_NOP      = 32'h0000_0013;

   logic         clk = 1'b0;
   logic         reset;
   logic         imem_req_valid;
   logic         imem_req_ready;
   logic [31:0]  imem_addr;
   logic         imem_rsp_valid;
   logic [31:0]  imem_rsp_data;
   logic         instr_valid;
   logic [31:0]  instr;
   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   logic         instr_ack;
   logic         branch, zero, jump, jalr;
   logic [31:0]  imm_ext;
   logic [31:0]  alu_result;
   logic         fault;
   fetch_state_e state;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_pc;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .instr_ack      (instr_ack),
      .branch         (branch),
      .zero           (zero),
      .jump           (jump),
      .jalr           (jalr),
      .imm_ext        (imm_ext),
      .alu_result     (alu_result),
      .fault          (fault),
      .state          (state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic br, input logic z,
                                                 input logic j, input logic jr, input logic [31:0] imm,
                                                 input logic [31:0] alu);
      if (jr) return alu & ~32'd1;
      if (j || (br && z)) return cur + imm;
      return cur + 32'd4;
   endfunction

   // ---------------- drivers (phase: #1 after posedge) ----------------
   task automatic clear_ctrl();
      instr_ack = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; jalr = 1'b0;
      imm_ext = '0; alu_result = '0;
   endtask

   // Wait for a request, accept it at once, return the word next cycle.
   task automatic do_fetch(input logic [31:0] data, output logic [31:0] addr, output logic ok);
      int n;
      n = 0; ok = 1'b0; addr = '0;
      while (!imem_req_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      if (!imem_req_valid) return;
      addr = imem_addr;
      imem_req_ready = 1'b1;
      @(posedge clk); #1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = data;
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
      ok = instr_valid;
   endtask

   task automatic do_ack(input logic br, input logic z, input logic j, input logic jr,
                         input logic [31:0] imm, input logic [31:0] alu);
      branch = br; zero = z; jump = j; jalr = jr; imm_ext = imm; alu_result = alu;
      instr_ack = 1'b1;
      @(posedge clk); #1;
      clear_ctrl();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] a, d;
      logic        ok;
      // just released from reset: IDLE is quiet for one cycle
      tests_run++;
      if ({imem_req_valid, instr_valid, fault, pc} !== {3'b000, TB_RESET_PC}) begin
         tests_failed++;
         $display("FAIL reset_idle_quiet: req=%b iv=%b fault=%b pc=%h, required 0 0 0 %h",
                  imem_req_valid, instr_valid, fault, pc, TB_RESET_PC);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({imem_req_valid, imem_addr} !== {1'b1, TB_RESET_PC}) begin
         tests_failed++;
         $display("FAIL reset_first_req: req=%b addr=%h, required 1 %h", imem_req_valid, imem_addr, TB_RESET_PC);
      end
      d = $urandom;
      do_fetch(d, a, ok);
      tests_run++;
      if (ok !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_fetch_done: instr_valid=%b, required 1", ok);
      end
      // asynchronous reset mid-cycle from HOLD
      #3 reset = 1'b1;
      #1;
      tests_run++;
      if ({state, pc, instr, instr_valid, imem_req_valid, fault} !== {ST_IDLE, TB_RESET_PC, TB_NOP, 3'b000}) begin
         tests_failed++;
         $display("FAIL reset_async_values: state=%0d pc=%h instr=%h iv=%b req=%b fault=%b, required 0 %h %h 0 0 0",
                  state, pc, instr, instr_valid, imem_req_valid, fault, TB_RESET_PC, TB_NOP);
      end
      tests_run++;
      if (pc_plus4 !== TB_RESET_PC + 32'd4) begin
         tests_failed++;
         $display("FAIL reset_pc_plus4: got %h, required %h", pc_plus4, TB_RESET_PC + 32'd4);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_pc = TB_RESET_PC;
   endtask

   task automatic test_sequential();
      logic [31:0] a, d;
      logic        ok;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         do_fetch(d, a, ok);
         tests_run++;
         if ({ok, a, instr, pc_plus4} !== {1'b1, exp_pc, d, exp_pc + 32'd4}) begin
            tests_failed++;
            $display("FAIL seq_fetch[%0d]: ok=%b addr=%h instr=%h pc4=%h, required 1 %h %h %h",
                     i, ok, a, instr, pc_plus4, exp_pc, d, exp_pc + 32'd4);
         end
         do_ack(0, 0, 0, 0, $urandom, $urandom);
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_branch();
      logic [31:0] a;
      logic        ok;
      do_fetch($urandom, a, ok);
      tests_run++;
      if ({ok, a} !== {1'b1, 32'h10}) begin
         tests_failed++;
         $display("FAIL branch_start_pc: ok=%b addr=%h, required 1 00000010", ok, a);
      end
      do_ack(1, 1, 0, 0, 32'hFFFF_FFF8, $urandom);
      do_fetch($urandom, a, ok);
      tests_run++;
      if ({ok, a} !== {1'b1, 32'h08}) begin
         tests_failed++;
         $display("FAIL branch_taken: ok=%b addr=%h, required 1 00000008", ok, a);
      end
      do_ack(0, 0, 0, 0, 0, 0);
      do_fetch($urandom, a, ok);
      do_ack(0, 0, 0, 0, 0, 0);
      do_fetch($urandom, a, ok);
      tests_run++;
      if ({ok, a} !== {1'b1, 32'h10}) begin
         tests_failed++;
         $display("FAIL branch_return_pc: ok=%b addr=%h, required 1 00000010", ok, a);
      end
      do_ack(1, 0, 0, 0, 32'hFFFF_FFF8, $urandom);
      do_fetch($urandom, a, ok);
      tests_run++;
      if ({ok, a} !== {1'b1, 32'h14}) begin
         tests_failed++;
         $display("FAIL branch_not_taken: ok=%b addr=%h, required 1 00000014", ok, a);
      end
      do_ack(0, 0, 0, 0, 0, 0);
      exp_pc = 32'h18;
   endtask

   // ready held low: request stable, stray rsp_valid/instr_ack ignored
   task automatic test_stall();
      logic [31:0] d;
      int          n;
      n = 0;
      while (!imem_req_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      tests_run++;
      if ({imem_req_valid, imem_addr} !== {1'b1, exp_pc}) begin
         tests_failed++;
         $display("FAIL stall_req_start: req=%b addr=%h, required 1 %h", imem_req_valid, imem_addr, exp_pc);
      end
      for (int i = 0; i < 5; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         instr_ack = 1'($urandom_range(0, 1));
         jump = 1'b1; imm_ext = 32'h40;
         @(posedge clk); #1;
         tests_run++;
         if ({imem_req_valid, imem_addr, instr_valid} !== {1'b1, exp_pc, 1'b0}) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: req=%b addr=%h iv=%b, required 1 %h 0",
                     i, imem_req_valid, imem_addr, instr_valid, exp_pc);
         end
      end
      clear_ctrl();
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      imem_req_ready = 1'b0;
      tests_run++;
      if ({imem_req_valid, state} !== {1'b0, ST_WAIT}) begin
         tests_failed++;
         $display("FAIL stall_single_req: req=%b state=%0d, required 0 %0d", imem_req_valid, state, ST_WAIT);
      end
      d = $urandom;
      imem_rsp_valid = 1'b1; imem_rsp_data = d;
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      tests_run++;
      if ({instr_valid, instr} !== {1'b1, d}) begin
         tests_failed++;
         $display("FAIL stall_rsp: iv=%b instr=%h, required 1 %h", instr_valid, instr, d);
      end
      do_ack(0, 0, 0, 0, 0, 0);
      exp_pc = exp_pc + 32'd4;
   endtask

   task automatic test_random();
      logic [31:0] a, d, imm, alu;
      logic        ok, br, z, j, jr;
      for (int i = 0; i < 20; i++) begin
         d = $urandom;
         do_fetch(d, a, ok);
         tests_run++;
         if ({ok, a, instr} !== {1'b1, exp_pc, d}) begin
            tests_failed++;
            $display("FAIL random_fetch[%0d]: ok=%b addr=%h instr=%h, required 1 %h %h", i, ok, a, instr, exp_pc, d);
         end
         br  = 1'($urandom_range(0, 1));
         z   = 1'($urandom_range(0, 1));
         j   = ($urandom_range(0, 3) == 0);
         jr  = ($urandom_range(0, 3) == 0);
         imm = $urandom & 32'hFFFF_FFFC;
         alu = $urandom & 32'hFFFF_FFFD;
         do_ack(br, z, j, jr, imm, alu);
         exp_pc = model_next_pc(exp_pc, br, z, j, jr, imm, alu);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] a;
      logic        ok;
      do_fetch($urandom, a, ok);
      do_ack(0, 0, 1, 0, 32'hFFFF_FFFC - exp_pc, 0);
      do_fetch($urandom, a, ok);
      tests_run++;
      if ({ok, a, pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
         tests_failed++;
         $display("FAIL wrap_top: ok=%b addr=%h pc4=%h, required 1 fffffffc 00000000", ok, a, pc_plus4);
      end
      do_ack(0, 0, 0, 0, 0, 0);
      tests_run++;
      if ({pc, pc_plus4, imem_req_valid, imem_addr} !== {32'h0, 32'h4, 1'b1, 32'h0}) begin
         tests_failed++;
         $display("FAIL wrap_zero: pc=%h pc4=%h req=%b addr=%h, required 0 4 1 0", pc, pc_plus4, imem_req_valid, imem_addr);
      end
      exp_pc = 32'h0;
   endtask

   task automatic test_jalr_fault();
      logic [31:0] a;
      logic        ok, seen;
      do_fetch($urandom, a, ok);
      tests_run++;
      if ({ok, a} !== {1'b1, exp_pc}) begin
         tests_failed++;
         $display("FAIL fault_fetch: ok=%b addr=%h, required 1 %h", ok, a, exp_pc);
      end
      do_ack(0, 0, 1, 1, $urandom, 32'h0000_0103);
      tests_run++;
      if ({fault, state, pc, instr_valid, imem_req_valid} !== {1'b1, ST_FAULT, exp_pc, 2'b00}) begin
         tests_failed++;
         $display("FAIL fault_entry: fault=%b state=%0d pc=%h iv=%b req=%b, required 1 %0d %h 0 0",
                  fault, state, pc, instr_valid, imem_req_valid, ST_FAULT, exp_pc);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         imem_req_ready = 1'b1;
         imem_rsp_valid = 1'($urandom_range(0, 1));
         instr_ack = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (imem_req_valid || instr_valid || !fault) seen = 1'b1;
      end
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; clear_ctrl();
      tests_run++;
      if (seen !== 1'b0) begin
         tests_failed++;
         $display("FAIL fault_sticky: activity seen=%b, required 0", seen);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] a, d;
      logic        ok;
      int          n;
      #3 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tests_run++;
      if (fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstwait_fault_clear: fault=%b, required 0", fault);
      end
      n = 0;
      while (!imem_req_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      imem_req_ready = 1'b1;
      @(posedge clk); #1;
      imem_req_ready = 1'b0;
      tests_run++;
      if (state !== ST_WAIT) begin
         tests_failed++;
         $display("FAIL rstwait_in_wait: state=%0d, required %0d", state, ST_WAIT);
      end
      #3 reset = 1'b1;
      #1;
      @(posedge clk); #1;
      reset = 1'b0;
      d = $urandom;
      imem_rsp_valid = 1'b1; imem_rsp_data = d;
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      tests_run++;
      if ({instr_valid, instr, imem_req_valid, imem_addr} !== {1'b0, TB_NOP, 1'b1, TB_RESET_PC}) begin
         tests_failed++;
         $display("FAIL rstwait_stale_rsp: iv=%b instr=%h req=%b addr=%h, required 0 %h 1 %h",
                  instr_valid, instr, imem_req_valid, imem_addr, TB_NOP, TB_RESET_PC);
      end
      d = $urandom;
      do_fetch(d, a, ok);
      tests_run++;
      if ({ok, a, instr} !== {1'b1, TB_RESET_PC, d}) begin
         tests_failed++;
         $display("FAIL rstwait_restart: ok=%b addr=%h instr=%h, required 1 %h %h", ok, a, instr, TB_RESET_PC, d);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      clear_ctrl();
      exp_pc = TB_RESET_PC;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_random();
      test_wrap();
      test_jalr_fault();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
